// File: rtl/glb_ifmap_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// glb_ifmap_rd_arbiter_pkg : shared types for the ifmap GLB read arbiter
// Revision : 1.0
// ============================================================================
package glb_ifmap_rd_arbiter_pkg;

   localparam int CNT_W     = 16;
   localparam int c_MAX_REQ = 32;
   localparam int c_ID_W    = $clog2(c_MAX_REQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } arb_state_t;

   // One slot of the read-return pipe: which FIFO the returning word belongs to
   typedef struct packed {
      logic              valid;
      logic [c_ID_W-1:0] id;
   } ret_entry_t;

endpackage
`default_nettype wire

// File: rtl/glb_ifmap_rd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// glb_ifmap_rd_arbiter_rr_pick : first set request at or after a pointer, wrapping
// Revision : 1.0
// ============================================================================
module glb_ifmap_rd_arbiter_rr_pick #(
   parameter int WIDTH = 32,
   parameter int PTR_W = 5
) (
   input  logic [WIDTH-1:0] i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_valid
);

   int               w_j;
   logic [PTR_W-1:0] w_cand;

   // i_ptr is always below WIDTH, so one subtraction is enough to wrap
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_j     = 0;
      w_cand  = '0;
      for (int k = 0; k < WIDTH; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= WIDTH) begin
            w_j = w_j - WIDTH;
         end
         w_cand = PTR_W'(w_j);
         if (!o_valid && i_req[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/glb_ifmap_rd_arbiter.sv
`default_nettype none
// ============================================================================
// glb_ifmap_rd_arbiter : round-robin GLB read scheduler feeding the ifmap FIFOs
// Optional stall counter output when GLB_RD_STALL_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module glb_ifmap_rd_arbiter
   import glb_ifmap_rd_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 32,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int ADDR_STEP = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      init_i,
   input  logic [NUM_REQ*ADDR_W-1:0] base_addr_i,
   input  logic [NUM_REQ-1:0]        enable_mask_i,
   input  logic [CNT_W-1:0]          words_i,
   input  logic [NUM_REQ-1:0]        req_i,
   output logic                      glb_rd_en_o,
   output logic [ADDR_W-1:0]         glb_rd_addr_o,
   input  logic                      glb_gnt_i,
   input  logic [DATA_W-1:0]         glb_rd_data_i,
   output logic [NUM_REQ-1:0]        fifo_push_o,
   output logic [DATA_W-1:0]         fifo_push_data_o,
   output logic                      busy_o,
   output logic                      done_o
`ifdef GLB_RD_STALL_CNT_EN
   ,
   output logic [31:0]               stall_cnt_o
`endif
);

   localparam int                c_PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W-1:0] c_ADDR_INC = ADDR_W'(ADDR_STEP);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;

   logic [ADDR_W-1:0]   r_addr   [NUM_REQ];
   logic [CNT_W-1:0]    r_remain [NUM_REQ];
   logic [NUM_REQ-1:0]  r_en;
   logic [NUM_REQ-1:0]  r_inflight;
   logic [c_PTR_W-1:0]  r_rr;
   ret_entry_t          r_pipe   [RD_LAT];

   logic [NUM_REQ-1:0]  w_remain_nz;
   logic [NUM_REQ-1:0]  w_elig;
   logic [NUM_REQ-1:0]  w_fire_onehot;
   logic [NUM_REQ-1:0]  w_ret_onehot;
   logic [c_PTR_W-1:0]  w_grant;
   logic [c_PTR_W-1:0]  w_rr_nxt;
   logic                w_grant_vld;
   logic                w_run;
   logic                w_fire;
   logic                w_all_done;
   logic                w_ret_vld;
   ret_entry_t          w_ret;

   // ---------------------------------------------------------------- per FIFO
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign w_remain_nz[g]   = |r_remain[g];
      assign w_elig[g]        = r_en[g] & req_i[g] & ~r_inflight[g] & w_remain_nz[g];
      assign w_fire_onehot[g] = w_fire && (w_grant == c_PTR_W'(g));
      assign w_ret_onehot[g]  = w_ret_vld && (w_ret.id == c_ID_W'(g));
   end

   glb_ifmap_rd_arbiter_rr_pick #(
      .WIDTH (NUM_REQ),
      .PTR_W (c_PTR_W)
   ) u_rr_pick (
      .i_req   (w_elig),
      .i_ptr   (r_rr),
      .o_idx   (w_grant),
      .o_valid (w_grant_vld)
   );

   assign w_run         = (r_state == ST_RUN);
   assign glb_rd_en_o   = w_run & w_grant_vld;
   assign glb_rd_addr_o = glb_rd_en_o ? r_addr[w_grant] : '0;
   assign w_fire        = glb_rd_en_o & glb_gnt_i;
   assign w_rr_nxt      = (w_grant == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

   // Pipe entries never outlive their inflight bit, so inflight alone tracks drain
   assign w_all_done = ~|(r_en & w_remain_nz) & ~|r_inflight;

   // Data arriving in the cycle a new tile is started belongs to the old tile
   assign w_ret            = r_pipe[RD_LAT-1];
   assign w_ret_vld        = w_ret.valid & ~init_i;
   assign fifo_push_o      = w_ret_onehot;
   assign fifo_push_data_o = glb_rd_data_i;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_IDLE;
         end
         ST_LOAD: begin
            busy_o      = 1'b1;
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy_o = 1'b1;
            if (w_all_done) begin
               done_o      = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (init_i) begin
         w_state_nxt = ST_LOAD;
      end
   end

   // ---------------------------------------------------------------- pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_addr[i]   <= '0;
            r_remain[i] <= '0;
         end
         r_en       <= '0;
         r_inflight <= '0;
         r_rr       <= '0;
      end else if (init_i) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_addr[i]   <= base_addr_i[i*ADDR_W +: ADDR_W];
            r_remain[i] <= words_i;
         end
         r_en       <= enable_mask_i;
         r_inflight <= '0;
         r_rr       <= '0;
      end else begin
         if (w_fire) begin
            r_addr[w_grant]   <= r_addr[w_grant] + c_ADDR_INC;
            r_remain[w_grant] <= r_remain[w_grant] - 1'b1;
            r_rr              <= w_rr_nxt;
         end
         r_inflight <= (r_inflight | w_fire_onehot) & ~w_ret_onehot;
      end
   end

   // ---------------------------------------------------------------- return pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < RD_LAT; k++) begin
            r_pipe[k] <= '0;
         end
      end else if (init_i) begin
         for (int k = 0; k < RD_LAT; k++) begin
            r_pipe[k] <= '0;
         end
      end else begin
         r_pipe[0].valid <= w_fire;
         r_pipe[0].id    <= c_ID_W'(w_grant);
         for (int k = 1; k < RD_LAT; k++) begin
            r_pipe[k] <= r_pipe[k-1];
         end
      end
   end

`ifdef GLB_RD_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (init_i) begin
         r_stall_cnt <= '0;
      end else if (glb_rd_en_o && !glb_gnt_i && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/glb_ifmap_rd_arbiter.md
# glb_ifmap_rd_arbiter

Round-robin read scheduler that shares the single GLB read port among the NUM_REQ ifmap FIFOs of the token engine. It sits between the L2C FIFO/PE initialisation stage, which supplies per-FIFO base addresses, and the GLB read port. It walks each FIFO's address stream, issues one GLB read per cycle when the port is granted, and steers each returning word into the requesting FIFO. It signals `done_o` when every enabled FIFO has received its programmed word count.

## Interface
- NUM_REQ, 32, number of ifmap FIFOs served
- ADDR_W, 32, GLB address width
- DATA_W, 32, GLB read data width
- RD_LAT, 1, GLB read latency in cycles (1..4)
- ADDR_STEP, 4, address increment per issued read
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- init_i  input  1  one-cycle pulse: load bases/counts, clear pointers, start
- base_addr_i  input  ADDR_W x NUM_REQ  per-FIFO GLB base address, sampled on init_i
- enable_mask_i  input  NUM_REQ  FIFOs taking part in this tile, sampled on init_i
- words_i  input  16  reads per enabled FIFO, sampled on init_i
- req_i  input  NUM_REQ  FIFO has at least one free slot
- glb_rd_en_o  output  1  read request valid
- glb_rd_addr_o  output  ADDR_W  read address
- glb_gnt_i  input  1  GLB port accepts the request this cycle
- glb_rd_data_i  input  DATA_W  read data, valid RD_LAT cycles after accept
- fifo_push_o  output  NUM_REQ  one-hot push strobe
- fifo_push_data_o  output  DATA_W  push data, equal to glb_rd_data_i
- busy_o  output  1  state is LOAD or RUN
- done_o  output  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, RUN, DONE.
  - IDLE→LOAD on init_i.
  - LOAD lasts 1 cycle and then goes to RUN.
  - RUN→DONE when every enabled FIFO is finished and nothing is in flight.
  - DONE→IDLE unconditionally.
  - init_i in any state goes to LOAD.
- LOAD actions:
  - addr[i] = base_addr_i[i] and remain[i] = words_i.
  - Inflight bits cleared; rr pointer = 0.
  - words_i = 0 or enable_mask_i = 0 gives LOAD→RUN→DONE with no reads.
- Eligibility: eligible[i] = en[i] & req_i[i] & ~inflight[i] & (remain[i] != 0).
  - At most one outstanding read per FIFO, so a FIFO needs only one free slot.
- Grant: the first eligible index at or after rr, with wrap-around.
  - glb_rd_en_o = RUN & |eligible.
  - glb_rd_addr_o = addr[grant].
- Fire = glb_rd_en_o & glb_gnt_i. On fire:
  - addr[grant] += ADDR_STEP (modulo 2^ADDR_W).
  - remain[grant] -= 1 and inflight[grant] = 1.
  - rr = grant+1, wrapping NUM_REQ-1→0.
- Without fire: rr, addr and remain hold, and the chosen index may change next cycle.
- Return path: an RD_LAT-deep shift register carries {valid, id}.
  - At the output stage: fifo_push_o[id] = 1, fifo_push_data_o = glb_rd_data_i, inflight[id] cleared.
  - A fire and a return for the same id in the same cycle are impossible, because inflight blocks eligibility.
- init_i while reads are in flight: the shift register valids are cleared, and late data is dropped with no push.

## Timing
- Reset values:
  - glb_rd_en_o=0, glb_rd_addr_o=0, fifo_push_o=0, fifo_push_data_o passes glb_rd_data_i, busy_o=0, done_o=0.
  - State IDLE; all addr, remain, inflight and rr cleared.
- glb_rd_en_o and glb_rd_addr_o are combinational from registered state and req_i. glb_gnt_i must not depend on glb_rd_en_o combinationally.
- First possible issue is 2 cycles after init_i (LOAD, then RUN).
- Push for a fire in cycle t occurs in cycle t+RD_LAT.
- Throughput: 1 read per cycle while at least 2 FIFOs are eligible. A single FIFO alone gets 1 read per RD_LAT+1 cycles.
- done_o asserts the cycle after the last push.

## Configuration
- GLB_RD_STALL_CNT_EN defined:
  - Adds output stall_cnt_o[31:0], which counts RUN cycles with glb_rd_en_o=1 & glb_gnt_i=0.
  - The counter is cleared on reset and on init_i, and saturates at 2^32-1.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package:
  - arbiter state enum (IDLE/LOAD/RUN/DONE);
  - return-pipe entry typedef {valid, id[$clog2(NUM_REQ)-1:0]};
  - localparam CNT_W=16.
- Sub-module rr_pick: combinational round-robin find-first from a pointer, parameterised by width.

## Test plan
- Single FIFO: en=0x1, base[0]=0x100, words=3, gnt=1, RD_LAT=1.
  - Reads at 0x100, 0x104, 0x108, one every 2 cycles.
  - 3 pushes to FIFO 0, then done_o.
- Four FIFOs: en=0xF, words=2, all req=1.
  - Grant order 0,1,2,3,0,1,2,3 with no idle cycles.
  - Exactly 8 pushes, each to the correct one-hot position.
- Backpressure: gnt toggles 1,0,1,0.
  - Address and rr hold on non-fire cycles, with no duplicate or skipped address.
  - stall_cnt_o equals the number of 0-gnt cycles.
- req_i[2] low for 5 cycles with en=0x7: FIFO 2 is skipped, reads resume at its next address, and the total count is unchanged.
- Abort: init_i pulsed while 1 read is in flight with RD_LAT=3.
  - The returning word is not pushed.
  - The new bases are used, and the next issue comes 2 cycles after init_i.
- Reset: rst_n asserted mid-RUN clears all outputs to their reset values immediately; words=0 → done_o 2 cycles after init_i, with zero reads.
